// File: rtl/multicore_debug_cmd_arbiter.sv
// Round-robin arbiter sharing one debug command channel among NUM_CORES debug slaves.
// Issues a one-cycle take_action strobe, then waits for the selected core's response or a timeout.
module multicore_debug_cmd_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int TIMEOUT   = 1023,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CORES-1:0]    req,
    input  logic [2*NUM_CORES-1:0]  req_cmd,
    input  logic [38*NUM_CORES-1:0] req_jdo,
    output logic [NUM_CORES-1:0]    ack,
    output logic [1:0]              status,
    output logic [NUM_CORES-1:0]    core_sel,
    output logic [3:0]              take_action,
    output logic [37:0]             jdo,
    input  logic [NUM_CORES-1:0]    monitor_ready,
    input  logic [NUM_CORES-1:0]    monitor_error,
    output logic                    busy
);

    localparam int IDX_W = $clog2(NUM_CORES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] g;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] pick;
    logic             found;

    logic [37:0] jdo_arr [NUM_CORES];
    logic [1:0]  cmd_arr [NUM_CORES];

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_unpack
        assign jdo_arr[k] = req_jdo[k*38 +: 38];
        assign cmd_arr[k] = req_cmd[k*2 +: 2];
    end

    // First requester at or after ptr, wrapping around.
    always_comb begin
        int j;
        j     = 0;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_CORES) j = j - NUM_CORES;
            if (!found && req[IDX_W'(j)]) begin
                found = 1'b1;
                pick  = IDX_W'(j);
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            g           <= '0;
            cnt         <= '0;
            ack         <= '0;
            status      <= 2'd0;
            core_sel    <= '0;
            take_action <= 4'b0000;
            jdo         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        g           <= pick;
                        core_sel    <= NUM_CORES'(1) << pick;
                        jdo         <= jdo_arr[pick];
                        take_action <= 4'b0001 << cmd_arr[pick];
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    take_action <= 4'b0000;
                    cnt         <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    // cnt is zero only on the first WAIT cycle, where ready may be stale.
                    if (monitor_error[g]) begin
                        status <= 2'd1;
                        ack    <= NUM_CORES'(1) << g;
                        state  <= DONE;
                    end else if (monitor_ready[g] && cnt != '0) begin
                        status <= 2'd0;
                        ack    <= NUM_CORES'(1) << g;
                        state  <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        status <= 2'd2;
                        ack    <= NUM_CORES'(1) << g;
                        state  <= DONE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    ack      <= '0;
                    core_sel <= '0;
                    ptr      <= (g == IDX_W'(NUM_CORES-1)) ? '0 : g + 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/multicore_debug_cmd_arbiter.md
Name: multicore_debug_cmd_arbiter

Overview:
Shares one debug command channel (38-bit jdo payload plus action code) among NUM_CORES Nios II debug slaves in the multicore system. Requesters (host-side debug agents) post commands; the block grants them round-robin. It issues a one-cycle take_action strobe to the selected core's debug slave, then waits for that core's monitor_ready/monitor_error, with a timeout. It runs entirely in the sysclk domain, downstream of the per-core JTAG-to-sysclk synchronisers.

Parameters:
NUM_CORES, 4, number of requesters and cores (2..8)
TIMEOUT, 1023, cycles to wait for monitor response before flagging timeout (1..65535)
CNT_W, 16, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
req  in  NUM_CORES  per-requester command request, level, held until ack
req_cmd  in  2*NUM_CORES  per-requester action code: 0 break_a, 1 break_b, 2 break_c, 3 ocimem_a
req_jdo  in  38*NUM_CORES  per-requester payload
ack  out  NUM_CORES  one-cycle completion pulse to the granted requester
status  out  2  valid with ack: 0 ok, 1 monitor_error, 2 timeout
core_sel  out  NUM_CORES  one-hot target core, held from ISSUE through DONE
take_action  out  4  one-hot action strobe (bit = req_cmd), one cycle, to core_sel core
jdo  out  38  payload, registered, stable while core_sel nonzero
monitor_ready  in  NUM_CORES  per-core ready, level
monitor_error  in  NUM_CORES  per-core error, level
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; ack=0, status=0, core_sel=0, take_action=0, jdo=0, busy=0; round-robin pointer = 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req, pick the first set bit searching from ptr upward with wrap, index g. Register core_sel=1<<g and jdo=req_jdo[g]; go to ISSUE. With no req, stay in IDLE.
- ISSUE (1 cycle): take_action[req_cmd[g]]=1. Clear the timeout counter. Go to WAIT.
- WAIT: the response is sampled only from core g. Priority order:
  - monitor_error[g]=1 gives status=1 (error beats ready when both are high).
  - else monitor_ready[g]=1 gives status=0.
  - else when the counter reaches TIMEOUT, status=2.
  - otherwise increment the counter (saturating) and stay in WAIT.
  - Any exit goes to DONE.
- WAIT entry: monitor_ready is ignored on the first WAIT cycle, because it can still be high from the previous command. Earliest completion is therefore 2 cycles after ISSUE.
- DONE (1 cycle): ack[g]=1 with status valid. ptr = (g+1) mod NUM_CORES. core_sel=0. Go to IDLE.
- Latency: req to take_action is 2 cycles (IDLE sample, then ISSUE). Minimum req to ack is 5 cycles. The minimum gap between commands from one requester is 1 idle cycle, since the requester must drop req on ack.
- Request handling: req, req_cmd and req_jdo are sampled only in IDLE. Changes after grant are ignored. Deasserting req after grant does not abort the command, and the ack is still issued.
- Fairness: with all requesters active, grants go 0,1,2,…,N-1,0 in order. No requester waits more than NUM_CORES-1 commands.
- Reset mid-operation clears everything immediately. No ack is issued for the aborted command.
- take_action is never asserted with core_sel=0. At most one take_action bit is high, and only in ISSUE.
- Counter: CNT_W bits, saturates, and never wraps.

Test Plan:
- Single request: req[1]=1, cmd=3, jdo=0x2A_DEAD_BEEF; monitor_ready[1] rises 3 cycles after ISSUE -> take_action=4'b1000 for 1 cycle, core_sel=4'b0010, jdo=0x2ADEADBEEF, then ack[1]=1 with status=0.
- Round-robin: req=4'b1111 held, each core readies immediately -> grant order 0,1,2,3,0 and exactly one ack per command.
- Error priority: monitor_error[2]=1 and monitor_ready[2]=1 in the same cycle -> status=1. Separately, ready on a non-selected core (monitor_ready[0]=1 while g=2) -> ignored, stays in WAIT.
- Timeout: TIMEOUT=8, core never responds -> ack with status=2, arriving 8 or 9 WAIT cycles after ISSUE; busy drops the cycle after DONE.
- Stale ready: monitor_ready[0] held high continuously -> first WAIT cycle is ignored and ack arrives no earlier than 2 cycles after ISSUE.
- Reset in WAIT: assert reset while in WAIT -> all outputs 0 asynchronously; after release, no ack is seen and the next grant starts at ptr=0.
